univ_shift_reg_n: RTL and testbench



---
 rtl/univ_shift_reg_n.sv | 92 +++++++++
 tb/tb_univ_shift_reg_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with load/shift/rotate/arith-shift modes
// and a self-timed burst-shift engine reporting busy/done.
//
// state | meaning
// IDLE  | accepts mode commands when en=1
// BUSY  | burst in progress, one shift per enabled edge, cnt counts down
// DONE  | single-cycle completion pulse, also accepts commands
module univ_shift_reg_n #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sinl,
   input  logic             sinr,
   input  logic             dir,
   input  logic [LW-1:0]    burst_len,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_nx;
   logic [LW-1:0]    cnt, cnt_nx, len;
   logic             dir_r, dir_nx;

   assign len    = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign busy   = (state == BUSY);
   assign done   = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         dir_r <= 1'b0;
      end else begin
         state <= state_nx;
         q     <= q_nx;
         cnt   <= cnt_nx;
         dir_r <= dir_nx;
      end
   end

   always_comb begin
      state_nx = state;
      q_nx     = q;
      cnt_nx   = cnt;
      dir_nx   = dir_r;
      if (state == BUSY) begin
         if (en) begin
            q_nx   = dir_r ? {q[WIDTH-2:0], sinl} : {sinr, q[WIDTH-1:1]};
            cnt_nx = cnt - LW'(1);
            if (cnt == LW'(1))
               state_nx = DONE;
         end
      end else begin
         // DONE falls back to IDLE unless a burst start below overrides it
         if (state == DONE)
            state_nx = IDLE;
         if (en) begin
            case (mode)
               3'b000: q_nx = din;
               3'b001: q_nx = {q[WIDTH-2:0], sinl};
               3'b010: q_nx = {sinr, q[WIDTH-1:1]};
               3'b011: q_nx = q;
               3'b100: q_nx = {q[WIDTH-2:0], q[WIDTH-1]};
               3'b101: q_nx = {q[0], q[WIDTH-1:1]};
               3'b110: q_nx = {q[WIDTH-1], q[WIDTH-1:1]};
               3'b111: begin
                  dir_nx   = dir;
                  cnt_nx   = len;
                  state_nx = (len == '0) ? DONE : BUSY;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Scoreboard bench for univ_shift_reg_n (WIDTH=8): directed vectors push expected
// register/status values, a monitor pops and compares after each edge or reset.
module tb_univ_shift_reg_n;

   logic       clk, rst, en, sinl, sinr, dir;
   logic [2:0] mode;
   logic [7:0] din, q;
   logic [3:0] burst_len;
   logic       sout_l, sout_r, busy, done;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
      logic       sl;
      logic       sr;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   localparam logic [2:0] LD = 3'b000, SHL = 3'b001, SHR = 3'b010, HLD = 3'b011,
                          ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, BST = 3'b111;

   univ_shift_reg_n #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .sinl(sinl),
      .sinr(sinr), .dir(dir), .burst_len(burst_len), .q(q), .sout_l(sout_l),
      .sout_r(sout_r), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input logic [7:0] eq, input logic eb, input logic ed, input string nm);
      exp_t e;
      e.q = eq; e.busy = eb; e.done = ed; e.sl = eq[7]; e.sr = eq[0];
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sl, input logic sr, input logic dr, input logic [3:0] bl,
                      input logic [7:0] eq, input logic eb, input logic ed, input string nm);
      @(negedge clk);
      en = e; mode = m; din = d; sinl = sl; sinr = sr; dir = dr; burst_len = bl;
      push(eq, eb, ed, nm);
   endtask

   // monitor: one expected entry per edge or reset assertion
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (q !== e.q || busy !== e.busy || done !== e.done ||
                sout_l !== e.sl || sout_r !== e.sr) begin
               errors++;
               $display("FAIL %s: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b sl=%b sr=%b",
                        nm, q, busy, done, sout_l, sout_r, e.q, e.busy, e.done, e.sl, e.sr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; en = 1'b0; mode = HLD; din = 8'h00;
      sinl = 1'b0; sinr = 1'b0; dir = 1'b0; burst_len = 4'd0;
      #2;
      push(8'h00, 1'b0, 1'b0, "reset_state");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // basic modes
      cyc(1, LD,  8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0, "load_a5");
      cyc(1, SHL, 8'h00, 1, 0, 0, 0, 8'h4B, 0, 0, "shl");
      cyc(1, SHR, 8'h00, 0, 0, 0, 0, 8'h25, 0, 0, "shr");
      cyc(1, HLD, 8'hFF, 1, 1, 0, 0, 8'h25, 0, 0, "hold");
      cyc(0, LD,  8'hFF, 1, 1, 0, 0, 8'h25, 0, 0, "en0_load");
      cyc(0, BST, 8'hFF, 1, 1, 0, 3, 8'h25, 0, 0, "en0_burst");
      cyc(1, LD,  8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "load_81");
      cyc(1, ROL, 8'h00, 0, 0, 0, 0, 8'h03, 0, 0, "rotl");
      cyc(1, LD,  8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "load_81b");
      cyc(1, ROR, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0, "rotr");
      cyc(1, LD,  8'h90, 0, 0, 0, 0, 8'h90, 0, 0, "load_90");
      cyc(1, ASR, 8'h00, 0, 0, 0, 0, 8'hC8, 0, 0, "ashr1");
      cyc(1, ASR, 8'h00, 0, 0, 0, 0, 8'hE4, 0, 0, "ashr2");

      // burst right len=3; mode/din during BUSY must be ignored
      cyc(1, LD,  8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "load_f0");
      cyc(1, BST, 8'h00, 0, 0, 0, 3, 8'hF0, 1, 0, "burst_start");
      cyc(1, LD,  8'h00, 0, 0, 1, 9, 8'h78, 1, 0, "burst_s1");
      cyc(1, LD,  8'h00, 0, 0, 1, 9, 8'h3C, 1, 0, "burst_s2");
      cyc(1, LD,  8'h00, 0, 0, 1, 9, 8'h1E, 0, 1, "burst_done");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 0, "burst_idle");

      // stalled burst
      cyc(1, LD,  8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "st_load");
      cyc(1, BST, 8'h00, 0, 0, 0, 3, 8'hF0, 1, 0, "st_start");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h78, 1, 0, "st_s1");
      cyc(0, HLD, 8'h00, 0, 1, 0, 0, 8'h78, 1, 0, "st_stall1");
      cyc(0, HLD, 8'h00, 0, 1, 0, 0, 8'h78, 1, 0, "st_stall2");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h3C, 1, 0, "st_s2");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 1, "st_done");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 0, "st_idle");

      // zero-length burst
      cyc(1, BST, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 1, "len0_done");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h1E, 0, 0, "len0_idle");

      // len=12 clamps to 8 left shifts
      cyc(1, LD,  8'hFF, 0, 0, 0, 0, 8'hFF, 0, 0, "cl_load");
      cyc(1, BST, 8'h00, 0, 0, 1, 12, 8'hFF, 1, 0, "cl_start");
      for (int k = 1; k <= 7; k++)
         cyc(1, HLD, 8'h00, 0, 1, 0, 0, 8'hFF << k, 1, 0, "cl_shift");
      cyc(1, HLD, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, "cl_done");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "cl_idle");

      // back-to-back burst started in DONE, live sinl fill
      cyc(1, LD,  8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "bb_load");
      cyc(1, BST, 8'h00, 0, 0, 0, 1, 8'hF0, 1, 0, "bb_start1");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h78, 0, 1, "bb_done1");
      cyc(1, BST, 8'h00, 1, 0, 1, 2, 8'h78, 1, 0, "bb_start2");
      cyc(1, HLD, 8'h00, 1, 0, 0, 0, 8'hF1, 1, 0, "bb_s1");
      cyc(1, HLD, 8'h00, 1, 0, 0, 0, 8'hE3, 0, 1, "bb_done2");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'hE3, 0, 0, "bb_idle");

      // async reset mid-burst after two shifts
      cyc(1, LD,  8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "rs_load");
      cyc(1, BST, 8'h00, 0, 0, 0, 5, 8'hF0, 1, 0, "rs_start");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h78, 1, 0, "rs_s1");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h3C, 1, 0, "rs_s2");
      @(negedge clk);
      #2;
      push(8'h00, 0, 0, "rs_async");
      rst = 1'b1;
      push(8'h00, 0, 0, "rs_held");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, LD,  8'h5A, 0, 0, 0, 0, 8'h5A, 0, 0, "rs_reload");
      cyc(1, HLD, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0, "rs_idle");

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
